// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/operand/result bundle between the control unit and the mult/div engine.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;
    modport master(output start, op, a, b, input hi, lo, busy, done, div0);
    modport slave(input start, op, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide, one bit per cycle on magnitudes, signs fixed up at the end.
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] acc, acc_n, prod;
    logic [WIDTH-1:0] mb, quo, rem;
    logic [WIDTH:0] sum, sh, diff;
    logic [CW-1:0] cnt;
    logic sa, sb, opr, bzero;
    assign bzero = bus.op && bus.b == '0;
    assign bus.busy = state != IDLE;
    // acc holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
        sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = sh - {1'b0, mb};
        acc_n = !opr ? {sum, acc[WIDTH-1:1]}
              : diff[WIDTH] ? {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
              : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod = (sa ^ sb) ? -acc : acc;
        quo = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        state_n = state == IDLE ? ((bus.start && !bzero) ? ITER : IDLE)
                : state == ITER ? (cnt == CW'(1) ? FIX : ITER)
                : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.hi <= '0;
            bus.lo <= '0;
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mb <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            opr <= 1'b0;
        end else begin
            state <= state_n;
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
            if (state == IDLE && bus.start) begin
                if (bzero) begin
                    bus.done <= 1'b1;
                    bus.div0 <= 1'b1;
                end else begin
                    acc <= {{WIDTH{1'b0}}, bus.a[WIDTH-1] ? -bus.a : bus.a};
                    mb <= bus.b[WIDTH-1] ? -bus.b : bus.b;
                    sa <= bus.a[WIDTH-1];
                    sb <= bus.b[WIDTH-1];
                    opr <= bus.op;
                    cnt <= CW'(WIDTH);
                end
            end
            if (state == ITER) begin
                acc <= acc_n;
                cnt <= cnt - CW'(1);
            end
            if (state == FIX) begin
                {bus.hi, bus.lo} <= opr ? {rem, quo} : prod;
                bus.done <= 1'b1;
            end
        end
    end
endmodule
